// File: rtl/pearl_pkg.sv
// Shared types for the branch resolve slice.
// Branch types, compare op codes, resolve FSM states.
package pearl_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_COND = 2'd1,
    BR_JAL  = 2'd2,
    BR_JALR = 2'd3
  } br_type_e;

  localparam logic [2:0] BCU_BEQ  = 3'b000;
  localparam logic [2:0] BCU_BNE  = 3'b001;
  localparam logic [2:0] BCU_BLT  = 3'b100;
  localparam logic [2:0] BCU_BGE  = 3'b101;
  localparam logic [2:0] BCU_BLTU = 3'b110;
  localparam logic [2:0] BCU_BGEU = 3'b111;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } brs_state_e;

endpackage

// File: rtl/brnch_perf_cnt.sv
// Enable counter with synchronous reset, wraps mod 2^CNT_W.
// Ports: clk_i, rst_i, en_i (count), cnt_o (value).
module brnch_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: target, redirect handshake, flush.
// Ports: ex_* instruction in, redirect_* out, flush/stall, link, counters.
module branch_resolve_unit
  import pearl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ex_valid_i,
  input  logic [1:0]       ex_br_type_i,
  input  logic [XLEN-1:0]  ex_pc_i,
  input  logic [XLEN-1:0]  ex_rs1_i,
  input  logic [XLEN-1:0]  ex_imm_i,
  input  logic             tk_brnch_i,
  input  logic             kill_i,
  input  logic             redirect_ready_i,
  output logic             redirect_valid_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic             flush_o,
  output logic             ex_stall_o,
  output logic [XLEN-1:0]  link_o,
  output logic             misalign_exc_o,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  br_type_e        br_ty;
  brs_state_e      state_q, state_d;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] tgt;
  logic            taken;
  logic            resolve;
  logic            launch;
  logic            misal;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            rv_q, rv_d;
  logic            fl_q, fl_d;
  logic            st_q, st_d;
  logic            mx_q, mx_d;

  assign br_ty = br_type_e'(ex_br_type_i);

  always_comb begin
    sum = ex_pc_i + ex_imm_i;
    tgt = sum;
    if (br_ty == BR_JALR) begin
      sum = ex_rs1_i + ex_imm_i;
      tgt = {sum[XLEN-1:1], 1'b0};
    end
  end

  assign taken   = (br_ty == BR_COND && tk_brnch_i)
                || br_ty == BR_JAL
                || br_ty == BR_JALR;
  assign resolve = ex_valid_i && state_q == IDLE && !kill_i;
  assign misal   = resolve && taken && tgt[1];
  assign launch  = resolve && taken && !tgt[1];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rv_d    = rv_q;
    fl_d    = fl_q;
    st_d    = st_q;
    mx_d    = 1'b0;
    if (kill_i) begin
      state_d = IDLE;
      rv_d    = 1'b0;
      fl_d    = 1'b0;
      st_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          mx_d = misal;
          if (launch) begin
            state_d = REDIRECT;
            pc_d    = tgt;
            rv_d    = 1'b1;
            fl_d    = 1'b1;
            st_d    = 1'b1;
          end
        end
        REDIRECT: begin
          if (redirect_ready_i) begin
            state_d = IDLE;
            rv_d    = 1'b0;
            fl_d    = 1'b0;
            st_d    = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= '0;
      rv_q    <= 1'b0;
      fl_q    <= 1'b0;
      st_q    <= 1'b0;
      mx_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rv_q    <= rv_d;
      fl_q    <= fl_d;
      st_q    <= st_d;
      mx_q    <= mx_d;
    end
  end

  brnch_perf_cnt #(.CNT_W(CNT_W)) u_br_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (resolve && br_ty != BR_NONE),
    .cnt_o (br_cnt_o)
  );

  brnch_perf_cnt #(.CNT_W(CNT_W)) u_mp_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (launch),
    .cnt_o (mispred_cnt_o)
  );

  assign redirect_valid_o = rv_q;
  assign redirect_pc_o    = pc_q;
  assign flush_o          = fl_q;
  assign ex_stall_o       = st_q;
  assign misalign_exc_o   = mx_q;
  assign link_o           = ex_pc_i + XLEN'(4);

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a cycle model.
// Model updated on posedge, compared on negedge.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [1:0]  ex_ty;
  logic [31:0] ex_pc, ex_rs1, ex_imm;
  logic        tk, kill, rdy;
  logic        rv, fl, st, mx;
  logic [31:0] rpc, link, brc, mpc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(32), .CNT_W(32)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .ex_valid_i       (ex_valid),
    .ex_br_type_i     (ex_ty),
    .ex_pc_i          (ex_pc),
    .ex_rs1_i         (ex_rs1),
    .ex_imm_i         (ex_imm),
    .tk_brnch_i       (tk),
    .kill_i           (kill),
    .redirect_ready_i (rdy),
    .redirect_valid_o (rv),
    .redirect_pc_o    (rpc),
    .flush_o          (fl),
    .ex_stall_o       (st),
    .link_o           (link),
    .misalign_exc_o   (mx),
    .br_cnt_o         (brc),
    .mispred_cnt_o    (mpc)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model: a pending redirect plus counters, driven by the rules.
  logic        m_on = 1'b0;
  logic        m_pend = 1'b0;
  logic        m_mis = 1'b0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_br = '0;
  logic [31:0] m_mp = '0;

  always @(posedge clk) begin
    logic        t;
    logic [31:0] g;
    m_on = 1'b1;
    if (ex_ty == 2'd3) g = (ex_rs1 + ex_imm) & 32'hFFFF_FFFE;
    else               g = ex_pc + ex_imm;
    t = (ex_ty == 2'd1 && tk) || ex_ty >= 2'd2;
    if (rst) begin
      m_pend = 0; m_mis = 0; m_pc = 0; m_br = 0; m_mp = 0;
    end else if (kill) begin
      m_pend = 0; m_mis = 0;
    end else if (m_pend) begin
      m_mis = 0;
      if (rdy) m_pend = 0;
    end else begin
      m_mis = 0;
      if (ex_valid && ex_ty != 2'd0) begin
        m_br = m_br + 1;
        if (t && g[1]) m_mis = 1;
        else if (t) begin
          m_pend = 1; m_pc = g; m_mp = m_mp + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("valid", {63'd0, rv}, {63'd0, m_pend});
      chk("flush", {63'd0, fl}, {63'd0, m_pend});
      chk("stall", {63'd0, st}, {63'd0, m_pend});
      chk("misal", {63'd0, mx}, {63'd0, m_mis});
      chk("rpc",   {32'd0, rpc}, {32'd0, m_pc});
      chk("brcnt", {32'd0, brc}, {32'd0, m_br});
      chk("mpcnt", {32'd0, mpc}, {32'd0, m_mp});
      chk("link",  {32'd0, link}, {32'd0, ex_pc + 32'd4});
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [1:0] t,
                     input logic [31:0] pc, input logic [31:0] r1,
                     input logic [31:0] im, input logic k);
    ex_valid = v; ex_ty = t; ex_pc = pc;
    ex_rs1 = r1; ex_imm = im; tk = k;
  endtask

  task automatic idle();
    drv(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    rst = 1; kill = 0; rdy = 1;
    idle();
    tick(); tick();
    chk("rst_valid", {63'd0, rv}, 64'd0);
    chk("rst_pc", {32'd0, rpc}, 64'd0);
    chk("rst_br", {32'd0, brc}, 64'd0);
    rst = 0;
    tick();

    // 1: taken cond branch, fetch ready
    drv(1, 2'd1, 32'h100, 32'h0, 32'h20, 1);
    tick();
    idle();
    chk("t1_valid", {63'd0, rv}, 64'd1);
    chk("t1_pc", {32'd0, rpc}, 64'h120);
    chk("t1_flush", {63'd0, fl}, 64'd1);
    tick();
    chk("t1_idle", {63'd0, rv}, 64'd0);
    chk("t1_br", {32'd0, brc}, 64'd1);
    chk("t1_mp", {32'd0, mpc}, 64'd1);

    // 2: not-taken cond branch
    drv(1, 2'd1, 32'h200, 32'h0, 32'h8, 0);
    tick();
    idle();
    chk("t2_valid", {63'd0, rv}, 64'd0);
    chk("t2_flush", {63'd0, fl}, 64'd0);
    chk("t2_br", {32'd0, brc}, 64'd2);
    chk("t2_mp", {32'd0, mpc}, 64'd1);

    // 3: JALR clears bit 0; JAL misaligned
    drv(1, 2'd3, 32'h300, 32'h2003, 32'h1, 0);
    #1;
    chk("t3_link", {32'd0, link}, 64'h304);
    tick();
    idle();
    chk("t3_pc", {32'd0, rpc}, 64'h2004);
    chk("t3_valid", {63'd0, rv}, 64'd1);
    tick();
    drv(1, 2'd2, 32'h10, 32'h0, 32'h6, 0);
    tick();
    idle();
    chk("t3_misal", {63'd0, mx}, 64'd1);
    chk("t3_norv", {63'd0, rv}, 64'd0);
    tick();
    chk("t3_pulse", {63'd0, mx}, 64'd0);
    chk("t3_mp", {32'd0, mpc}, 64'd2);
    chk("t3_br", {32'd0, brc}, 64'd4);

    // 4: backpressure for 3 cycles, wrong-path branch ignored
    rdy = 0;
    drv(1, 2'd1, 32'h400, 32'h0, 32'h40, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      drv(1, 2'd2, 32'h500, 32'h0, 32'h100, 0);
      chk("t4_hold_pc", {32'd0, rpc}, 64'h440);
      chk("t4_stall", {63'd0, st}, 64'd1);
    end
    rdy = 1;
    idle();
    tick();
    chk("t4_done", {63'd0, rv}, 64'd0);
    chk("t4_mp", {32'd0, mpc}, 64'd3);
    chk("t4_br", {32'd0, brc}, 64'd5);

    // 5: kill beats ready, then reset mid-redirect
    rdy = 0;
    drv(1, 2'd1, 32'h600, 32'h0, 32'h10, 1);
    tick();
    chk("t5_valid", {63'd0, rv}, 64'd1);
    kill = 1; rdy = 1;
    drv(1, 2'd2, 32'h700, 32'h0, 32'h8, 0);
    tick();
    kill = 0;
    idle();
    chk("t5_kill_rv", {63'd0, rv}, 64'd0);
    chk("t5_kill_fl", {63'd0, fl}, 64'd0);
    chk("t5_mp", {32'd0, mpc}, 64'd4);
    chk("t5_br", {32'd0, brc}, 64'd6);
    rdy = 0;
    drv(1, 2'd2, 32'h800, 32'h0, 32'h20, 0);
    tick();
    idle();
    chk("t5_rv2", {63'd0, rv}, 64'd1);
    rst = 1;
    tick();
    rst = 0; rdy = 1;
    chk("t5_rst_rv", {63'd0, rv}, 64'd0);
    chk("t5_rst_st", {63'd0, st}, 64'd0);
    chk("t5_rst_pc", {32'd0, rpc}, 64'd0);
    chk("t5_rst_mp", {32'd0, mpc}, 64'd0);

    // 6: target wrap, counter wrap
    drv(1, 2'd1, 32'hFFFF_FFF0, 32'h0, 32'h20, 1);
    tick();
    idle();
    chk("t6_wrap_pc", {32'd0, rpc}, 64'h10);
    tick();
    force dut.u_br_cnt.cnt_q = 32'hFFFF_FFFF;
    m_br = 32'hFFFF_FFFF;
    #1;
    release dut.u_br_cnt.cnt_q;
    drv(1, 2'd1, 32'h900, 32'h0, 32'h4, 0);
    tick();
    idle();
    chk("t6_cnt_wrap", {32'd0, brc}, 64'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
